// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding, port index type
// and the modular index helper used by the round-robin picker.
package sram_arbiter_pkg;

    localparam int MAX_PORTS = 4;
    localparam int IDX_W     = $clog2(MAX_PORTS);

    typedef logic [IDX_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // (base + offset) mod num_ports, used to walk the ports after the last winner.
    function automatic port_idx_t wrap_index(port_idx_t base, int offset, int num_ports);
        int sum;
        sum = (int'(base) + offset) % num_ports;
        return port_idx_t'(sum);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM_interface-side signals of the arbiter, bundled so
// the arbiter sees a single port; slave is the arbiter's view.
interface sram_arbiter_if #(
    parameter int NUM_PORTS = 3
);
    logic [NUM_PORTS-1:0]    request;
    logic [NUM_PORTS-1:0]    rw;
    logic [32*NUM_PORTS-1:0] address;
    logic [32*NUM_PORTS-1:0] wdata;
    logic [31:0]             rdata;
    logic [NUM_PORTS-1:0]    ready;

    logic                    sram_request;
    logic                    sram_rw;
    logic [31:0]             sram_address;
    logic [31:0]             sram_wdata;
    logic [31:0]             sram_rdata;
    logic                    sram_ready;

    modport slave (
        input  request, rw, address, wdata, sram_rdata, sram_ready,
        output rdata, ready, sram_request, sram_rw, sram_address, sram_wdata
    );

    modport master (
        output request, rw, address, wdata, sram_rdata, sram_ready,
        input  rdata, ready, sram_request, sram_rw, sram_address, sram_wdata
    );

endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester after 'last',
// with an optional override that lets port 0 win whenever it asks.
module rr_pick
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0] request,
    input  port_idx_t            last,
    input  logic                 prio0,
    output logic                 valid,
    output port_idx_t            index
);

    // Scan from the farthest candidate (last itself) down to last+1 so the nearest one wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (request[wrap_index(last, k, NUM_PORTS)]) begin
                valid = 1'b1;
                index = wrap_index(last, k, NUM_PORTS);
            end
        end
        if (prio0 && request[0]) begin
            valid = 1'b1;
            index = '0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM_interface among NUM_PORTS requesters,
// with a forced idle cycle between transactions so the SRAM cycle counter restarts.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int PORT0_PRIO = 0
) (
    input  logic          i_clock,
    input  logic          i_reset,
    sram_arbiter_if.slave bus
);

    arb_state_t           state;
    port_idx_t            grant;
    port_idx_t            last;
    port_idx_t            pick_index;
    logic                 pick_valid;
    logic [NUM_PORTS-1:0] ready_vec;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .request (bus.request),
        .last    (last),
        .prio0   (PORT0_PRIO != 0),
        .valid   (pick_valid),
        .index   (pick_index)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= port_idx_t'(NUM_PORTS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_index;
                        last  <= pick_index;
                        state <= ST_BUSY;
                    end
                end
                // A dropped request before ready is an abort: leave without signalling ready.
                ST_BUSY: begin
                    if (bus.sram_ready || !bus.request[grant]) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (pick_valid) begin
                        grant <= pick_index;
                        last  <= pick_index;
                        state <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.sram_request = 1'b0;
        bus.sram_rw      = 1'b0;
        bus.sram_address = '0;
        bus.sram_wdata   = '0;
        ready_vec        = '0;
        if (state == ST_BUSY) begin
            bus.sram_request = 1'b1;
            bus.sram_rw      = bus.rw[grant];
            bus.sram_address = bus.address[32*int'(grant) +: 32];
            bus.sram_wdata   = bus.wdata[32*int'(grant) +: 32];
            ready_vec[grant] = bus.sram_ready;
        end
    end

    assign bus.ready = ready_vec;
    assign bus.rdata = bus.sram_rdata;

    // Ready must reach at most one port, and a completed transaction must be followed by a low cycle.
    a_ready_onehot: assert property (@(posedge i_clock) disable iff (i_reset)
        $onehot0(bus.ready));
    a_gap_after_ready: assert property (@(posedge i_clock) disable iff (i_reset)
        (bus.sram_request && bus.sram_ready) |=> !bus.sram_request);

endmodule
